// File: rtl/apb_master.sv
// APB initiator: single-beat valid/ready commands become APB SETUP/ACCESS transfers.
// Define APB_TIMEOUT_EN to add the RD_WAIT watchdog (abort after TIMEOUT cycles without pvalid).
module apb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pvalid,
    input  logic [DATA_W-1:0] prdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        RD_WAIT = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   rd_done;
    logic   rd_abort;

    assign cmd_ready = (state == IDLE);
    assign busy      = ~cmd_ready;
    assign accept    = cmd_valid && cmd_ready;
    // The responder's strobe only means something while we are waiting for it.
    assign rd_done   = (state == RD_WAIT) && pvalid;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] to_cnt;

    // Abort fires in the cycle the count would reach TIMEOUT; pvalid in that cycle wins.
    assign rd_abort = (state == RD_WAIT) && !pvalid && (to_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt  <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (state == ACCESS)
                to_cnt <= '0;
            else if ((state == RD_WAIT) && !pvalid)
                to_cnt <= to_cnt + 1'b1;
            rsp_err <= rd_abort;
        end
    end
`else
    assign rd_abort = 1'b0;
    assign rsp_err  = 1'b0;
`endif

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  state_nxt = pwrite ? IDLE : RD_WAIT;
            RD_WAIT: if (rd_done || rd_abort) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nxt;
            // APB strobes are registered from the next state, so they line up with it.
            psel      <= (state_nxt == SETUP) || (state_nxt == ACCESS);
            penable   <= (state_nxt == ACCESS);
            rsp_valid <= ((state == ACCESS) && pwrite) || rd_done || rd_abort;

            if (accept) begin
                pwrite <= cmd_write;
                paddr  <= cmd_addr;
                pwdata <= cmd_wdata;
            end

            if (rd_done)
                rsp_rdata <= prdata;
            else if (rd_abort)
                rsp_rdata <= '1;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master with a small memory-backed APB responder model.
module tb_apb_master;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr  = '0;
    logic [31:0] cmd_wdata = '0;
    logic        cmd_ready, busy, rsp_valid, rsp_err;
    logic        psel, penable, pwrite;
    logic [31:0] rsp_rdata, paddr, pwdata;
    logic        pvalid;
    logic        pv_q = 1'b0;
    logic        block_pv = 1'b0;
    logic [31:0] prdata = '0;
    logic [31:0] mem [0:255];

    int n_checks = 0;
    int n_pass   = 0;
    int setups   = 0;
    int pulses   = 0;

    apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pvalid(pvalid), .prdata(prdata)
    );

    always #5 clk = ~clk;

    // Zero-wait responder: read data and valid strobe registered off the ACCESS phase.
    assign pvalid = pv_q && !block_pv;
    always @(posedge clk) begin
        pv_q <= 1'b0;
        if (psel && penable) begin
            if (pwrite) mem[paddr[7:0]] <= pwdata;
            else begin
                prdata <= mem[paddr[7:0]];
                pv_q   <= 1'b1;
            end
        end
        if (psel && !penable) setups <= setups + 1;
        if (rsp_valid) pulses <= pulses + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic err);
        int n;
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        tick();
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 200) begin tick(); lat++; end
        rd  = rsp_rdata;
        err = rsp_err;
    endtask

    vec_t        vecs [9];
    int          lat, n, s0, p0;
    logic [31:0] rd;
    logic        err, ok;

    initial begin
        vecs[0] = '{1'b1, 32'h10, 32'h0000_0001, 32'hDEAD_BEEF, 3};
        vecs[1] = '{1'b0, 32'h10, 32'h0,         32'h0000_0001, 4};
        vecs[2] = '{1'b1, 32'h80, 32'hA5A5_5A5A, 32'h0000_0001, 3};
        vecs[3] = '{1'b1, 32'hFF, 32'h0,         32'h0000_0001, 3};
        vecs[4] = '{1'b0, 32'h80, 32'h0,         32'hA5A5_5A5A, 4};
        vecs[5] = '{1'b0, 32'hFF, 32'h0,         32'h0000_0000, 4};
        vecs[6] = '{1'b1, 32'h00, 32'hFFFF_FFFF, 32'h0000_0000, 3};
        vecs[7] = '{1'b0, 32'h00, 32'h0,         32'hFFFF_FFFF, 4};
        vecs[8] = '{1'b0, 32'h05, 32'h0,         32'hDEAD_BEEF, 4};

        // Reset state, observed mid-reset.
        #12;
        check("rst psel", psel, 1'b0);
        check("rst penable", penable, 1'b0);
        check("rst rsp_valid", rsp_valid, 1'b0);
        check("rst cmd_ready", cmd_ready, 1'b1);
        check("rst busy", busy, 1'b0);
        check("rst paddr", paddr, 32'h0);
        check("rst pwdata", pwdata, 32'h0);
        check("rst rsp_rdata", rsp_rdata, 32'h0);
        check("rst rsp_err", rsp_err, 1'b0);
        rst = 1'b1;
        tick();

        // Write 0x05 <- DEADBEEF, cycle by cycle.
        cmd_write = 1'b1; cmd_addr = 32'h05; cmd_wdata = 32'hDEAD_BEEF; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("wr c1 psel", psel, 1'b1);
        check("wr c1 penable", penable, 1'b0);
        check("wr c1 cmd_ready", cmd_ready, 1'b0);
        tick();
        check("wr c2 psel", psel, 1'b1);
        check("wr c2 penable", penable, 1'b1);
        check("wr c2 pwrite", pwrite, 1'b1);
        check("wr c2 paddr", paddr, 32'h05);
        check("wr c2 pwdata", pwdata, 32'hDEAD_BEEF);
        tick();
        check("wr c3 rsp_valid", rsp_valid, 1'b1);
        check("wr c3 rsp_err", rsp_err, 1'b0);
        check("wr c3 cmd_ready", cmd_ready, 1'b1);
        check("wr mem5", mem[5], 32'hDEAD_BEEF);
        tick();
        check("wr c4 rsp_valid", rsp_valid, 1'b0);

        // Read-back 0x05, cycle by cycle.
        cmd_write = 1'b0; cmd_addr = 32'h05; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("rd c1 psel", psel, 1'b1);
        check("rd c1 pwrite", pwrite, 1'b0);
        tick();
        check("rd c2 penable", penable, 1'b1);
        tick();
        check("rd c3 psel", psel, 1'b0);
        check("rd c3 penable", penable, 1'b0);
        check("rd c3 rsp_valid", rsp_valid, 1'b0);
        check("rd c3 busy", busy, 1'b1);
        tick();
        check("rd c4 rsp_valid", rsp_valid, 1'b1);
        check("rd c4 rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("rd c4 rsp_err", rsp_err, 1'b0);
        tick();

        // Table-driven transfers.
        for (int i = 0; i < 9; i++) begin
            do_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, rd, err);
            check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d rsp_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d rsp_err", i), err, 1'b0);
            check($sformatf("vec%0d paddr", i), paddr, vecs[i].addr);
            check($sformatf("vec%0d pwrite", i), pwrite, vecs[i].wr);
            check($sformatf("vec%0d pwdata", i), pwdata, vecs[i].wdata);
            tick();
            check($sformatf("vec%0d single pulse", i), rsp_valid, 1'b0);
        end

        // Back-to-back: write 0x20 <- 1, read 0x20 accepted in the write's response cycle.
        s0 = setups; p0 = pulses;
        cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h1; cmd_valid = 1'b1;
        tick();
        cmd_write = 1'b0; cmd_wdata = 32'h0;
        tick();
        tick();
        check("b2b wr rsp_valid", rsp_valid, 1'b1);
        check("b2b cmd_ready", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        check("b2b rd c1 psel", psel, 1'b1);
        check("b2b rd c1 penable", penable, 1'b0);
        check("b2b rd c1 pwrite", pwrite, 1'b0);
        check("b2b rd c1 rsp_valid", rsp_valid, 1'b0);
        tick();
        tick();
        check("b2b rd_wait psel", psel, 1'b0);
        tick();
        check("b2b rd rsp_valid", rsp_valid, 1'b1);
        check("b2b rd rsp_rdata", rsp_rdata, 32'h1);
        tick();
        check("b2b setups", setups - s0, 2);
        check("b2b pulses", pulses - p0, 2);

        // Command hold: cmd_* churn while busy must not disturb the transfer.
        p0 = pulses;
        cmd_write = 1'b0; cmd_addr = 32'h05; cmd_wdata = 32'h1234_5678; cmd_valid = 1'b1;
        tick();
        ok = 1'b1; n = 0;
        while (!rsp_valid && n < 20) begin
            if (cmd_ready !== 1'b0 || paddr !== 32'h05 || pwdata !== 32'h1234_5678) ok = 1'b0;
            cmd_valid = n[0];
            cmd_addr  = $urandom;
            cmd_wdata = $urandom;
            cmd_write = 1'($urandom);
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        check("hold stable", ok, 1'b1);
        check("hold rsp_valid", rsp_valid, 1'b1);
        check("hold rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        repeat (6) tick();
        check("hold pulses", pulses - p0, 1);
        check("hold idle", cmd_ready, 1'b1);

        // Read with the responder's valid strobe suppressed.
        block_pv = 1'b1;
`ifdef APB_TIMEOUT_EN
        do_cmd(1'b0, 32'h05, 32'h0, lat, rd, err);
        check("timeout latency", lat, 3 + TIMEOUT);
        check("timeout rsp_err", err, 1'b1);
        check("timeout rsp_rdata", rd, 32'hFFFF_FFFF);
        tick();
        check("timeout single pulse", rsp_valid, 1'b0);
        block_pv = 1'b0;
        do_cmd(1'b0, 32'h05, 32'h0, lat, rd, err);
        check("post-timeout rdata", rd, 32'hDEAD_BEEF);
        check("post-timeout rsp_err", err, 1'b0);
        tick();
`else
        cmd_write = 1'b0; cmd_addr = 32'h05; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        ok = 1'b1;
        repeat (100) begin
            tick();
            if (!busy || rsp_valid) ok = 1'b0;
        end
        check("no-timeout busy held", ok, 1'b1);
        check("no-timeout rsp_err", rsp_err, 1'b0);
        block_pv = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
`endif

        // Reset asserted during ACCESS of a read.
        p0 = pulses;
        cmd_write = 1'b0; cmd_addr = 32'h80; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("mid-rst access psel", psel, 1'b1);
        check("mid-rst access penable", penable, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("mid-rst psel async", psel, 1'b0);
        check("mid-rst penable async", penable, 1'b0);
        check("mid-rst rsp_valid async", rsp_valid, 1'b0);
        check("mid-rst cmd_ready async", cmd_ready, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            tick();
            if (rsp_valid || !cmd_ready || psel) ok = 1'b0;
        end
        check("post-rst quiet", ok, 1'b1);
        check("post-rst no pulse", pulses - p0, 0);

        do_cmd(1'b0, 32'h80, 32'h0, lat, rd, err);
        check("post-rst rd latency", lat, 4);
        check("post-rst rd rdata", rd, 32'hA5A5_5A5A);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
